// File: rtl/iguana_pkg.sv
// iguana_pkg: shared types and constants for the Iguana Hyperbus configuration
// block.
//   hyper_addr_rule_t : one chip-select address rule (idx, start, end).
//   hyper_cfg_regs_t  : one complete PHY timing and address-rule set.
//   Off*              : byte offsets of the configuration registers.
//   Rst*              : reset values of the timing fields.
//   cfg_reset()       : builds the reset register set from a base address and a
//                       per-chip span.
package iguana_pkg;

   localparam int unsigned HypAddrWidth = 48;
   localparam int unsigned HypNumChips  = 2;

   typedef struct packed {
      logic [31:0]             idx;
      logic [HypAddrWidth-1:0] start_addr;
      logic [HypAddrWidth-1:0] end_addr;
   } hyper_addr_rule_t;

   typedef struct packed {
      logic [3:0]                         latency;
      logic                               fixed_lat;
      logic [15:0]                        tcsh;
      hyper_addr_rule_t [HypNumChips-1:0] rules;
   } hyper_cfg_regs_t;

   typedef enum logic {
      BusIdle = 1'b0,
      BusResp = 1'b1
   } bus_state_e;

   localparam logic [7:0] OffLatency  = 8'h00;
   localparam logic [7:0] OffFlags    = 8'h04;
   localparam logic [7:0] OffTcsh     = 8'h08;
   localparam logic [7:0] OffRuleBase = 8'h20;
   localparam logic [7:0] OffCommit   = 8'h40;
   localparam logic [7:0] OffStatus   = 8'h44;

   localparam logic [3:0]  RstLatency  = 4'd6;
   localparam logic        RstFixedLat = 1'b1;
   localparam logic [15:0] RstTcsh     = 16'd665;

   // Byte-lane merge of a write into the current register image.
   function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

   // Chip i covers [base + i*span, base + (i+1)*span).
   function automatic hyper_cfg_regs_t cfg_reset(input logic [HypAddrWidth-1:0] base,
                                                 input logic [HypAddrWidth-1:0] span);
      hyper_cfg_regs_t c;
      c.latency   = RstLatency;
      c.fixed_lat = RstFixedLat;
      c.tcsh      = RstTcsh;
      for (int i = 0; i < HypNumChips; i++) begin
         c.rules[i].idx        = 32'(i);
         c.rules[i].start_addr = base + HypAddrWidth'(i) * span;
         c.rules[i].end_addr   = c.rules[i].start_addr + span;
      end
      return c;
   endfunction

endpackage

// File: rtl/iguana_hyper_cfg_regs.sv
// iguana_hyper_cfg_regs: register-bus slave holding the Hyperbus PHY timing
// and chip address rules. Software edits a shadow set; a COMMIT request copies
// the shadow set into the active outputs in the first cycle the PHY is idle.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   reg_valid_i/write_i      request (valid held until reg_ready_o)
//   reg_addr_i               byte address, bits [7:2] decoded
//   reg_wdata_i/wstrb_i      write data and byte strobes
//   reg_ready_o              one-cycle response pulse
//   reg_rdata_o/error_o      response data / access error (valid with ready)
//   phy_idle_i               PHY has no transaction in flight
//   cfg_latency_o, cfg_fixed_lat_o, cfg_tcsh_max_o, addr_rules_o
//                            active configuration set
//   cfg_update_o             one-cycle pulse in the cycle the active set loads
//
// Bus FSM:
//   state   | meaning
//   BusIdle | waiting for a request; access is performed when valid is seen
//   BusResp | ready high for one cycle with rdata/error of that access
module iguana_hyper_cfg_regs
   import iguana_pkg::*;
#(
   parameter int unsigned          AddrWidth    = HypAddrWidth,
   parameter int unsigned          NumChips     = HypNumChips,
   parameter logic [AddrWidth-1:0] MemBase      = 'h8000_0000,
   parameter int unsigned          RstChipBytes = 8192
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  reg_valid_i,
   input  logic                                  reg_write_i,
   input  logic [AddrWidth-1:0]                  reg_addr_i,
   input  logic [31:0]                           reg_wdata_i,
   input  logic [3:0]                            reg_wstrb_i,
   output logic                                  reg_ready_o,
   output logic [31:0]                           reg_rdata_o,
   output logic                                  reg_error_o,
   input  logic                                  phy_idle_i,
   output logic [3:0]                            cfg_latency_o,
   output logic                                  cfg_fixed_lat_o,
   output logic [15:0]                           cfg_tcsh_max_o,
   output logic [NumChips*(32+2*AddrWidth)-1:0]  addr_rules_o,
   output logic                                  cfg_update_o
);

   localparam hyper_cfg_regs_t CfgRst =
      cfg_reset(HypAddrWidth'(MemBase), HypAddrWidth'(RstChipBytes));

   bus_state_e      state_q, state_d;
   hyper_cfg_regs_t shadow_q, shadow_d;
   hyper_cfg_regs_t active_q;
   logic            pending_q, pending_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            error_q, error_d;

   logic [7:0]      off;
   logic            hit, is_shadow;
   logic [31:0]     rd_word, wr_word;
   logic            access, acc_err, apply;

   logic unused_addr;
   assign unused_addr = ^{reg_addr_i[AddrWidth-1:8], reg_addr_i[1:0]};

   assign off    = {reg_addr_i[7:2], 2'b00};
   assign access = (state_q == BusIdle) && reg_valid_i;
   assign apply  = pending_q && phy_idle_i;

   // ---------------- bus FSM ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= BusIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BusIdle: if (reg_valid_i) state_d = BusResp;
         BusResp: state_d = BusIdle;
         default: state_d = BusIdle;
      endcase
   end

   always_comb begin
      reg_ready_o = (state_q == BusResp);
   end

   // ---------------- address decode / read mux ----------------
   always_comb begin
      hit       = 1'b0;
      is_shadow = 1'b0;
      rd_word   = '0;
      case (off)
         OffLatency: begin hit = 1'b1; is_shadow = 1'b1; rd_word = {28'd0, shadow_q.latency};   end
         OffFlags:   begin hit = 1'b1; is_shadow = 1'b1; rd_word = {31'd0, shadow_q.fixed_lat}; end
         OffTcsh:    begin hit = 1'b1; is_shadow = 1'b1; rd_word = {16'd0, shadow_q.tcsh};      end
         OffCommit:  begin hit = 1'b1; rd_word = {31'd0, pending_q};                           end
         OffStatus:  begin hit = 1'b1; rd_word = {30'd0, pending_q, phy_idle_i};               end
         default: ;
      endcase
      for (int i = 0; i < HypNumChips; i++) begin
         if (off[7:4] == 4'(OffRuleBase[7:4] + i)) begin
            hit       = 1'b1;
            is_shadow = 1'b1;
            case (off[3:2])
               2'd0: rd_word = shadow_q.rules[i].start_addr[31:0];
               2'd1: rd_word = 32'(shadow_q.rules[i].start_addr[HypAddrWidth-1:32]);
               2'd2: rd_word = shadow_q.rules[i].end_addr[31:0];
               default: rd_word = 32'(shadow_q.rules[i].end_addr[HypAddrWidth-1:32]);
            endcase
         end
      end
   end

   // Merging into the read image makes unimplemented upper bits drop out
   // naturally when the field slice is taken below.
   assign wr_word = apply_strb(rd_word, reg_wdata_i, reg_wstrb_i);

   assign acc_err = !hit
                 || (reg_write_i && (off == OffStatus))
                 || (reg_write_i && is_shadow && pending_q);

   // ---------------- access and commit update ----------------
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      rdata_d   = rdata_q;
      error_d   = error_q;

      if (apply) pending_d = 1'b0;

      if (access) begin
         rdata_d = '0;
         error_d = acc_err;
         if (!acc_err && !reg_write_i) rdata_d = rd_word;
         if (!acc_err && reg_write_i) begin
            case (off)
               OffLatency: shadow_d.latency   = wr_word[3:0];
               OffFlags:   shadow_d.fixed_lat = wr_word[0];
               OffTcsh:    shadow_d.tcsh      = wr_word[15:0];
               // A repeated commit while one is outstanding is absorbed.
               OffCommit:  if (wr_word[0] && !pending_q) pending_d = 1'b1;
               default: ;
            endcase
            for (int i = 0; i < HypNumChips; i++) begin
               if (off[7:4] == 4'(OffRuleBase[7:4] + i)) begin
                  case (off[3:2])
                     2'd0: shadow_d.rules[i].start_addr[31:0] = wr_word;
                     2'd1: shadow_d.rules[i].start_addr[HypAddrWidth-1:32] = wr_word[HypAddrWidth-33:0];
                     2'd2: shadow_d.rules[i].end_addr[31:0] = wr_word;
                     default: shadow_d.rules[i].end_addr[HypAddrWidth-1:32] = wr_word[HypAddrWidth-33:0];
                  endcase
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q  <= CfgRst;
         active_q  <= CfgRst;
         pending_q <= 1'b0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
         if (apply) active_q <= shadow_q;
      end
   end

   // ---------------- outputs ----------------
   assign reg_rdata_o     = reg_ready_o ? rdata_q : '0;
   assign reg_error_o     = reg_ready_o & error_q;
   assign cfg_latency_o   = active_q.latency;
   assign cfg_fixed_lat_o = active_q.fixed_lat;
   assign cfg_tcsh_max_o  = active_q.tcsh;
   assign addr_rules_o    = active_q.rules;
   assign cfg_update_o    = apply;

endmodule

// File: tb/tb_iguana_hyper_cfg_regs.sv
// tb_iguana_hyper_cfg_regs: directed and randomized register accesses against
// a word-image reference model; responses go through a scoreboard queue that
// a negedge monitor drains whenever the DUT raises ready.
module tb_iguana_hyper_cfg_regs;

   localparam int AW = 48;
   localparam int NC = 2;
   localparam int RW = 32 + 2*AW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           reg_valid = 1'b0;
   logic           reg_write = 1'b0;
   logic [AW-1:0]  reg_addr = '0;
   logic [31:0]    reg_wdata = '0;
   logic [3:0]     reg_wstrb = '0;
   logic           reg_ready;
   logic [31:0]    reg_rdata;
   logic           reg_error;
   logic           phy_idle = 1'b1;
   logic [3:0]     cfg_latency;
   logic           cfg_fixed_lat;
   logic [15:0]    cfg_tcsh;
   logic [NC*RW-1:0] addr_rules;
   logic           cfg_update;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iguana_hyper_cfg_regs #(
      .AddrWidth(AW), .NumChips(NC), .MemBase(48'h8000_0000), .RstChipBytes(8192)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
      .reg_wdata_i(reg_wdata), .reg_wstrb_i(reg_wstrb),
      .reg_ready_o(reg_ready), .reg_rdata_o(reg_rdata), .reg_error_o(reg_error),
      .phy_idle_i(phy_idle),
      .cfg_latency_o(cfg_latency), .cfg_fixed_lat_o(cfg_fixed_lat),
      .cfg_tcsh_max_o(cfg_tcsh), .addr_rules_o(addr_rules),
      .cfg_update_o(cfg_update)
   );

   // ---------------- reference model (word images) ----------------
   logic [31:0] m_sh  [64];
   logic [31:0] m_act [64];
   bit          m_pending;
   bit          exp_ready;
   bit          started = 1'b0;
   logic [32:0] exp_q [$];

   bit          drv_acc = 1'b0;
   bit          drv_wr = 1'b0;
   logic [5:0]  drv_word = '0;
   logic [31:0] drv_wd = '0;
   logic [3:0]  drv_ws = '0;

   // Implemented bits of a shadow register word; 0 when not a shadow register.
   function automatic logic [31:0] impl_mask(input int w);
      if (w == 0) return 32'h0000_000F;
      if (w == 1) return 32'h0000_0001;
      if (w == 2) return 32'h0000_FFFF;
      if (w >= 8 && w < 8 + 4*NC) return (w % 2 == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      return 32'h0;
   endfunction

   task automatic model_reset();
      longint unsigned s, e;
      for (int w = 0; w < 64; w++) m_sh[w] = '0;
      m_sh[0] = 32'd6;
      m_sh[1] = 32'd1;
      m_sh[2] = 32'd665;
      for (int i = 0; i < NC; i++) begin
         s = 64'h8000_0000 + 64'(i) * 64'd8192;
         e = s + 64'd8192;
         m_sh[8+4*i]  = s[31:0];
         m_sh[9+4*i]  = 32'(s >> 32);
         m_sh[10+4*i] = e[31:0];
         m_sh[11+4*i] = 32'(e >> 32);
      end
      m_act     = m_sh;
      m_pending = 1'b0;
   endtask

   function automatic logic [NC*RW-1:0] exp_rules();
      logic [NC*RW-1:0] v;
      v = '0;
      for (int i = 0; i < NC; i++)
         v[i*RW +: RW] = {32'(i), m_act[9+4*i][15:0], m_act[8+4*i],
                          m_act[11+4*i][15:0], m_act[10+4*i]};
      return v;
   endfunction

   always @(posedge clk) begin
      bit          app;
      int          w;
      logic [31:0] msk, bm;
      if (rst) begin
         model_reset();
         exp_ready = 1'b0;
         started   = 1'b1;
      end else begin
         app       = m_pending && phy_idle;
         exp_ready = drv_acc;
         if (drv_acc) begin
            w   = int'(drv_word);
            msk = impl_mask(w);
            if ((msk == 0 && w != 16 && w != 17) || (drv_wr && w == 17) ||
                (drv_wr && msk != 0 && m_pending)) begin
               exp_q.push_back({1'b1, 32'h0});
            end else if (!drv_wr) begin
               if (w == 16)      exp_q.push_back({1'b0, 31'h0, m_pending});
               else if (w == 17) exp_q.push_back({1'b0, 30'h0, m_pending, phy_idle});
               else              exp_q.push_back({1'b0, m_sh[w]});
            end else begin
               exp_q.push_back({1'b0, 32'h0});
               if (w == 16) begin
                  if (drv_wd[0] && drv_ws[0] && !m_pending) m_pending = 1'b1;
               end else begin
                  for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{drv_ws[b]}};
                  m_sh[w] = ((m_sh[w] & ~bm) | (drv_wd & bm)) & msk;
               end
            end
         end
         if (app) begin
            m_act     = m_sh;
            m_pending = 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   function automatic void check(input string name, input logic [255:0] act,
                                 input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      logic [32:0] e;
      if (started) begin
         check("ready", 256'(reg_ready), 256'(exp_ready));
         if (reg_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: got ready=1, expected no response (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("rdata", 256'(reg_rdata), 256'(e[31:0]));
               check("error", 256'(reg_error), 256'(e[32]));
            end
         end
         check("cfg_latency",   256'(cfg_latency),   256'(m_act[0][3:0]));
         check("cfg_fixed_lat", 256'(cfg_fixed_lat), 256'(m_act[1][0]));
         check("cfg_tcsh_max",  256'(cfg_tcsh),      256'(m_act[2][15:0]));
         check("addr_rules",    256'(addr_rules),    256'(exp_rules()));
         check("cfg_update",    256'(cfg_update),    256'(m_pending && phy_idle));
      end
   end

   // ---------------- driver ----------------
   task automatic bus(input bit wr, input logic [7:0] off, input logic [31:0] wd,
                      input logic [3:0] ws, input bit rst_mid);
      logic [AW-1:0] a;
      @(negedge clk);
      #1;
      a        = AW'({$urandom(), $urandom()});
      a[7:2]   = off[7:2];
      a[1:0]   = 2'($urandom_range(0, 3));
      reg_addr  = a;
      reg_write = wr;
      reg_wdata = wd;
      reg_wstrb = ws;
      reg_valid = 1'b1;
      drv_acc   = 1'b1;
      drv_wr    = wr;
      drv_word  = off[7:2];
      drv_wd    = wd;
      drv_ws    = ws;
      @(posedge clk);
      #1;
      drv_acc = 1'b0;
      if (rst_mid) rst = 1'b1;
      @(posedge clk);
      #1;
      reg_valid = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic set_idle(input bit v);
      @(negedge clk);
      #1;
      phy_idle = v;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] offs [16];

   initial begin
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h20, 8'h24, 8'h28, 8'h2C,
               8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h50, 8'hFC};
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset values
      bus(0, 8'h00, 0, 4'h0, 0);
      bus(0, 8'h08, 0, 4'h0, 0);
      bus(0, 8'h20, 0, 4'h0, 0);
      bus(0, 8'h30, 0, 4'h0, 0);
      bus(0, 8'h04, 0, 4'h0, 0);

      // commit with PHY idle
      bus(1, 8'h00, 32'h3, 4'hF, 0);
      bus(1, 8'h40, 32'h1, 4'hF, 0);
      wait_cyc(2);

      // commit held off by a busy PHY
      set_idle(0);
      bus(1, 8'h08, 32'd100, 4'hF, 0);
      bus(1, 8'h40, 32'h1, 4'hF, 0);
      bus(0, 8'h44, 0, 4'h0, 0);
      wait_cyc(5);
      bus(1, 8'h00, 32'h9, 4'hF, 0);
      bus(1, 8'h40, 32'h1, 4'hF, 0);
      bus(0, 8'h00, 0, 4'h0, 0);
      bus(0, 8'h40, 0, 4'h0, 0);
      set_idle(1);
      wait_cyc(2);
      bus(0, 8'h44, 0, 4'h0, 0);

      // byte strobes, unmapped, upper address bits, status write, no-op strobe
      bus(1, 8'h20, 32'h0000_AB00, 4'b0010, 0);
      bus(0, 8'h20, 0, 4'h0, 0);
      bus(0, 8'h50, 0, 4'h0, 0);
      bus(1, 8'h24, 32'hFFFF_FFFF, 4'hF, 0);
      bus(0, 8'h24, 0, 4'h0, 0);
      bus(1, 8'h44, 32'hFFFF_FFFF, 4'hF, 0);
      bus(1, 8'h08, 32'h1234_5678, 4'h0, 0);
      bus(0, 8'h08, 0, 4'h0, 0);
      bus(1, 8'h40, 32'h0, 4'hF, 0);
      bus(0, 8'h44, 0, 4'h0, 0);
      bus(1, 8'h40, 32'h1, 4'hF, 0);
      wait_cyc(2);

      // reset during a response with a commit pending
      set_idle(0);
      bus(1, 8'h00, 32'hA, 4'hF, 0);
      bus(1, 8'h40, 32'h1, 4'hF, 0);
      bus(0, 8'h44, 0, 4'h0, 1);
      wait_cyc(2);
      bus(0, 8'h44, 0, 4'h0, 0);
      bus(0, 8'h00, 0, 4'h0, 0);
      set_idle(1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [7:0]  o;
         logic [31:0] d;
         bit          wr;
         o  = offs[$urandom_range(0, 15)];
         wr = ($urandom_range(0, 1) == 1);
         d  = $urandom();
         if ($urandom_range(0, 7) == 0) begin
            o  = 8'h40;
            wr = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) set_idle($urandom_range(0, 3) != 0);
         bus(wr, o, d, 4'($urandom_range(0, 15)), 0);
         if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 3));
      end

      wait_cyc(4);
      check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iguana_hyper_cfg_regs.md
Name: iguana_hyper_cfg_regs

Overview:
- Register-bus slave at the Hyperbus configuration port (index 0, 0x4000_0000) of the Iguana Cheshire build.
- Holds shadow copies of the Hyperbus PHY timing configuration and the per-chip address rules.
- Commits the shadow copies to the active outputs only when the PHY reports idle.
- Drives the Hyperbus controller directly; its address-rule outputs feed the controller's chip-select decode.

Parameters:
- AddrWidth, 48, width of the rule start/end addresses (equals CheshireCfg.AddrWidth).
- NumChips, 2, number of chip rules (equals HypNumPhys*HypNumChips).
- MemBase, 'h8000_0000, reset start address of chip 0.
- RstChipBytes, 8192, reset span of each chip rule.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- reg_valid_i  in  1  request valid; held until reg_ready_o.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  AddrWidth  byte address; only bits [7:2] are decoded.
- reg_wdata_i  in  32  write data.
- reg_wstrb_i  in  4  byte strobes.
- reg_ready_o  out  1  response valid (one-cycle pulse).
- reg_rdata_o  out  32  read data.
- reg_error_o  out  1  access error.
- phy_idle_i  in  1  PHY has no transaction in flight.
- cfg_latency_o  out  4  active initial latency.
- cfg_fixed_lat_o  out  1  active fixed-latency enable.
- cfg_tcsh_max_o  out  16  active max CS-low cycles.
- addr_rules_o  out  NumChips*(32+2*AddrWidth)  active hyper_addr_rule_t array, packed.
- cfg_update_o  out  1  one-cycle pulse when an active set is loaded.

Behaviour:
- Register map (word offsets; R/W shadow unless noted):
  - 0x00 LATENCY [3:0], reset 6.
  - 0x04 FLAGS [0] fixed_lat, reset 1.
  - 0x08 TCSH [15:0], reset 665.
  - 0x20+0x10*i, rule i: +0 START_LO, +4 START_HI, +8 END_LO, +C END_HI. Upper bits above AddrWidth are read 0 and write-ignored.
  - 0x40 COMMIT: write bit0=1 requests a commit; read returns bit0 = pending.
  - 0x44 STATUS, read-only: [0] phy_idle_i, [1] pending.
- Rule reset values: start_i = MemBase + i*RstChipBytes; end_i = start_i + RstChipBytes; idx field fixed to i.
- Active registers reset to the same values as the shadow registers. All outputs reset to 0, except the config outputs, which show the active reset values.
- Bus FSM has two states:
  - IDLE: on reg_valid_i, perform the access and go to RESP.
  - RESP: reg_ready_o=1 for exactly one cycle, rdata/error valid, then IDLE.
  - Latency: ready asserts in the cycle after valid is first seen.
  - Back-to-back requests: the next request is sampled in the cycle after RESP.
- Writes apply reg_wstrb_i per byte; wstrb=0 is a legal no-op.
- Error (error=1, no state change, rdata=0) in these cases:
  - unmapped offset;
  - write to STATUS;
  - write to any shadow register while pending=1.
- COMMIT write with bit0=1 while pending=1: no effect, no error. Bit0=0: no effect.
- Commit logic:
  - pending is set at the COMMIT write.
  - In any cycle with pending=1 && phy_idle_i=1: all active registers load from shadow, pending clears, and cfg_update_o=1 for that one cycle.
  - Earliest apply is the cycle after the COMMIT write was performed.
  - If phy_idle_i stays 0, pending holds indefinitely.
- Active outputs never change except on an apply or on reset.
- Reset mid-operation: FSM returns to IDLE, pending clears, no ready pulse is issued, and shadow and active registers reload their reset values.
- The block performs no rule-overlap checking; software owns consistency.

Decomposition:
- iguana_pkg gains:
  - a hyper_cfg_regs_t struct (latency, fixed_lat, tcsh, rules);
  - register offset localparams;
  - reset-value localparams.
- The existing hyper_addr_rule_t is reused.
- No sub-module; shadow and active sets are two instances of the hyper_cfg_regs_t struct.

Test Plan:
- Reset: read 0x00, 0x08, 0x20, 0x30 -> 6, 665, 0x8000_0000, 0x8000_2000. cfg_latency_o=6, ready exactly 1 cycle after valid.
- Write 0x00=0x3 then COMMIT with phy_idle_i=1 -> cfg_latency_o=3 the cycle after the COMMIT response, cfg_update_o a single-cycle pulse.
- phy_idle_i=0, write TCSH=100, COMMIT -> outputs stay 665 and STATUS reads 0x2. Then phy_idle_i=1 -> cfg_tcsh_max_o=100, pending=0.
- While pending, write 0x00 -> error=1 and LATENCY unchanged. A second COMMIT -> no error, still one apply.
- Write 0x20 with wstrb=4'b0010, data 0x0000_AB00 -> START_LO=0x8000_AB00. Read 0x50 -> error=1, rdata=0.
- Assert rst_i during RESP with pending=1 -> no ready, pending=0, all outputs at reset values next cycle.
